// File: rtl/instruction_encoder_if.sv
// Field-level instruction input, instruction-memory write port and status for instruction_encoder.
// Checksum exists only when ENCODER_CHECKSUM_EN is defined.
interface instruction_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              Start;
    logic [ADDR_W-1:0] BaseAddr;
    logic [ADDR_W:0]   Count;
    logic              InValid;
    logic              InReady;
    logic [2:0]        Kind;
    logic [4:0]        Rs;
    logic [4:0]        Rt;
    logic [4:0]        Rd;
    logic [5:0]        Funct;
    logic [15:0]       Imm;
    logic [25:0]       Target;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic              Busy;
    logic              Done;
    logic              Error;
`ifdef ENCODER_CHECKSUM_EN
    logic [31:0]       Checksum;
`endif

    modport slave (
        input  Start, BaseAddr, Count, InValid, Kind, Rs, Rt, Rd, Funct, Imm, Target,
        output InReady, MemWE, MemAddr, MemWData, Busy, Done, Error
`ifdef ENCODER_CHECKSUM_EN
        , output Checksum
`endif
    );

    modport master (
        output Start, BaseAddr, Count, InValid, Kind, Rs, Rt, Rd, Funct, Imm, Target,
        input  InReady, MemWE, MemAddr, MemWData, Busy, Done, Error
`ifdef ENCODER_CHECKSUM_EN
        , input Checksum
`endif
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs MIPS instruction fields into 32-bit words and writes them to consecutive instruction-memory
// addresses. Optional XOR checksum of written words is enabled by ENCODER_CHECKSUM_EN.
module instruction_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rem;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
`ifdef ENCODER_CHECKSUM_EN
    logic [31:0]       r_csum;
`endif

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_xfer;

    // Field packing for the opcodes the control decoder recognises; anything else becomes a nop.
    always_comb begin
        w_word    = 32'h0000_0000;
        w_illegal = 1'b0;
        case (bus.Kind)
            3'd0:    w_word = {6'b000000, bus.Rs, bus.Rt, bus.Rd, 5'b00000, bus.Funct};
            3'd1:    w_word = {6'b100011, bus.Rs, bus.Rt, bus.Imm};
            3'd2:    w_word = {6'b101011, bus.Rs, bus.Rt, bus.Imm};
            3'd3:    w_word = {6'b000100, bus.Rs, bus.Rt, bus.Imm};
            3'd4:    w_word = {6'b001000, bus.Rs, bus.Rt, bus.Imm};
            3'd5:    w_word = {6'b000010, bus.Target};
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_xfer = bus.InValid & r_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0000_0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef ENCODER_CHECKSUM_EN
            r_csum      <= 32'h0000_0000;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_error <= 1'b0;
`ifdef ENCODER_CHECKSUM_EN
                        r_csum  <= 32'h0000_0000;
`endif
                        if (bus.Count != '0) begin
                            r_state    <= S_LOAD;
                            r_addr     <= bus.BaseAddr;
                            r_rem      <= bus.Count;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_word;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_rem       <= r_rem - (ADDR_W+1)'(1);
                        if (w_illegal) r_error <= 1'b1;
`ifdef ENCODER_CHECKSUM_EN
                        r_csum      <= r_csum ^ w_word;
`endif
                        // Last word: stop accepting now so the write drains during FLUSH.
                        if (r_rem == (ADDR_W+1)'(1)) begin
                            r_state    <= S_FLUSH;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.InReady  = r_in_ready;
    assign bus.MemWE    = r_mem_we;
    assign bus.MemAddr  = r_mem_addr;
    assign bus.MemWData = r_mem_wdata;
    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;
    assign bus.Error    = r_error;
`ifdef ENCODER_CHECKSUM_EN
    assign bus.Checksum = r_csum;
`endif
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder (ADDR_W=6).
module tb_instruction_encoder;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(AW)) bus();
    instruction_encoder #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            c;
    } wr_t;
    wr_t wq[$];

    always @(posedge clk) cyc++;

    // Record every write seen mid-cycle, with the cycle it occurred in.
    always @(negedge clk) begin
        if (bus.MemWE === 1'b1) wq.push_back('{bus.MemAddr, bus.MemWData, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [AW-1:0] base, input logic [AW:0] cnt);
        bus.Start    = 1'b1;
        bus.BaseAddr = base;
        bus.Count    = cnt;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                        input logic [25:0] tgt);
        bit acc;
        acc = 1'b0;
        bus.Kind = k; bus.Rs = rs; bus.Rt = rt; bus.Rd = rd;
        bus.Funct = f; bus.Imm = imm; bus.Target = tgt;
        bus.InValid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bus.InReady === 1'b1) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.InValid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_accept: accepted=%0d required=1", acc);
        end
    endtask

    task automatic wait_done(output int dc);
        bit seen;
        seen = 1'b0;
        dc = -1;
        for (int n = 0; n < 20; n++) begin
            if (bus.Done === 1'b1) begin
                seen = 1'b1;
                dc = cyc;
                break;
            end
            tick();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: Done=%b required=1", bus.Done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Start = 1'b0; bus.BaseAddr = '0; bus.Count = '0; bus.InValid = 1'b0;
        bus.Kind = '0; bus.Rs = '0; bus.Rt = '0; bus.Rd = '0;
        bus.Funct = '0; bus.Imm = '0; bus.Target = '0;
        repeat (3) tick();
        total++;
        if ({bus.InReady, bus.MemWE, bus.Busy, bus.Done, bus.Error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got=%b required=00000",
                     {bus.InReady, bus.MemWE, bus.Busy, bus.Done, bus.Error});
        end
        total++;
        if (bus.MemAddr !== '0 || bus.MemWData !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d data=%h required 0/0", bus.MemAddr, bus.MemWData);
        end
        reset = 1'b0;
        tick();
        total++;
        if (bus.Busy !== 1'b0 || bus.InReady !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: Busy=%b InReady=%b required 0/0", bus.Busy, bus.InReady);
        end
    endtask

    task automatic test_single_r();
        int wc, dc;
        wq.delete();
        start_seq(6'd0, 7'd1);
        total++;
        if (bus.InReady !== 1'b1) begin
            bad++;
            $display("FAIL single_inready: got=%b required=1", bus.InReady);
        end
        send(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0, 26'h0);
        wc = cyc;
        total++;
        if (bus.MemWE !== 1'b1 || bus.MemAddr !== 6'd0 || bus.MemWData !== 32'h01095020) begin
            bad++;
            $display("FAIL single_write: we=%b addr=%0d data=%h required 1/0/01095020",
                     bus.MemWE, bus.MemAddr, bus.MemWData);
        end
        wait_done(dc);
        total++;
        if (dc !== wc + 1) begin
            bad++;
            $display("FAIL single_done_cycle: got=%0d required=%0d", dc, wc + 1);
        end
        total++;
        if (bus.Busy !== 1'b0 || bus.Error !== 1'b0 || bus.MemWE !== 1'b0) begin
            bad++;
            $display("FAIL single_done_state: Busy=%b Error=%b MemWE=%b required 0/0/0",
                     bus.Busy, bus.Error, bus.MemWE);
        end
        tick();
        total++;
        if (bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_pulse: Done=%b required=0", bus.Done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expd[5];
        int dc;
        expd = '{32'h8FA80004, 32'hAFA80004, 32'h1000FFFF, 32'h20080005, 32'h08000010};
        wq.delete();
        start_seq(6'd0, 7'd5);
        send(3'd1, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        send(3'd2, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        send(3'd3, 5'd0,  5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        send(3'd4, 5'd0,  5'd8, 5'd0, 6'h0, 16'h0005, 26'h0);
        send(3'd5, 5'd0,  5'd0, 5'd0, 6'h0, 16'h0000, 26'h10);
        wait_done(dc);
        total++;
        if (wq.size() != 5) begin
            bad++;
            $display("FAIL b2b_count: got=%0d required=5", wq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (wq[i].addr !== AW'(i) || wq[i].data !== expd[i] || wq[i].c != wq[0].c + i) begin
                    bad++;
                    $display("FAIL b2b_word%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                             i, wq[i].addr, wq[i].data, wq[i].c, i, expd[i], wq[0].c + i);
                end
            end
            total++;
            if (dc != wq[4].c + 1) begin
                bad++;
                $display("FAIL b2b_done_cycle: got=%0d required=%0d", dc, wq[4].c + 1);
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        int dc;
        wq.delete();
        start_seq(6'd62, 7'd3);
        send(3'd4, 5'd1,  5'd2,  5'd0, 6'h0, 16'h0003, 26'h0);
        send(3'd5, 5'd0,  5'd0,  5'd0, 6'h0, 16'h0000, 26'h3FFFFFF);
        send(3'd2, 5'd31, 5'd31, 5'd0, 6'h0, 16'h8000, 26'h0);
        wait_done(dc);
        total++;
        if (wq.size() != 3 ||
            wq[0].addr !== 6'd62 || wq[0].data !== 32'h20220003 ||
            wq[1].addr !== 6'd63 || wq[1].data !== 32'h0BFFFFFF ||
            wq[2].addr !== 6'd0  || wq[2].data !== 32'hAFFF8000) begin
            bad++;
            $display("FAIL wrap: n=%0d required 3 writes 62:20220003 63:0BFFFFFF 0:AFFF8000", wq.size());
        end
        tick();
    endtask

    task automatic test_illegal();
        int dc;
        wq.delete();
        start_seq(6'd5, 7'd2);
        send(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0, 26'h0);
        send(3'd6, 5'd7, 5'd7, 5'd7,  6'h3F, 16'h1234, 26'h155);
        wait_done(dc);
        total++;
        if (wq.size() != 2 || wq[1].addr !== 6'd6 || wq[1].data !== 32'h0) begin
            bad++;
            $display("FAIL illegal_word: n=%0d required 2 writes with addr6 data 00000000", wq.size());
        end
        total++;
        if (bus.Error !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err_done: Error=%b required=1", bus.Error);
        end
        repeat (3) tick();
        total++;
        if (bus.Error !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err_sticky: Error=%b required=1", bus.Error);
        end
        start_seq(6'd0, 7'd0);
        total++;
        if (bus.Error !== 1'b0 || bus.Done !== 1'b1) begin
            bad++;
            $display("FAIL count0_clear: Error=%b Done=%b required 0/1", bus.Error, bus.Done);
        end
        tick();
        tick();
        total++;
        if (wq.size() != 2) begin
            bad++;
            $display("FAIL count0_nowrite: writes=%0d required=2", wq.size());
        end
    endtask

    task automatic test_gaps_start();
        int dc;
        wq.delete();
        start_seq(6'd20, 7'd3);
        send(3'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0010, 26'h0);
        bus.Start = 1'b1; bus.BaseAddr = 6'd40; bus.Count = 7'd1;
        tick();
        bus.Start = 1'b0;
        total++;
        if (bus.MemWE !== 1'b0 || bus.InReady !== 1'b1) begin
            bad++;
            $display("FAIL gap_idle: MemWE=%b InReady=%b required 0/1", bus.MemWE, bus.InReady);
        end
        tick();
        send(3'd3, 5'd4, 5'd5, 5'd0, 6'h0, 16'h0002, 26'h0);
        tick();
        send(3'd0, 5'd1, 5'd2, 5'd3, 6'h22, 16'h0, 26'h0);
        wait_done(dc);
        total++;
        if (wq.size() != 3 ||
            wq[0].addr !== 6'd20 || wq[0].data !== 32'h8C430010 ||
            wq[1].addr !== 6'd21 || wq[1].data !== 32'h10850002 ||
            wq[2].addr !== 6'd22 || wq[2].data !== 32'h00221822) begin
            bad++;
            $display("FAIL gaps: n=%0d required 3 writes 20:8C430010 21:10850002 22:00221822", wq.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        wq.delete();
        start_seq(6'd10, 7'd4);
        send(3'd1, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        send(3'd2, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        bus.Kind = 3'd4; bus.Rs = 5'd0; bus.Rt = 5'd8; bus.Imm = 16'h0005;
        bus.InValid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.InValid = 1'b0;
        total++;
        if ({bus.InReady, bus.MemWE, bus.Busy, bus.Done, bus.Error} !== 5'b0 ||
            bus.MemAddr !== '0 || bus.MemWData !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: ctrl=%b addr=%0d data=%h required all 0",
                     {bus.InReady, bus.MemWE, bus.Busy, bus.Done, bus.Error}, bus.MemAddr, bus.MemWData);
        end
        repeat (3) tick();
        total++;
        if (wq.size() != 2 || bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_writes: writes=%0d Busy=%b required 2/0", wq.size(), bus.Busy);
        end
    endtask

`ifdef ENCODER_CHECKSUM_EN
    task automatic test_checksum();
        int dc;
        start_seq(6'd0, 7'd2);
        total++;
        if (bus.Checksum !== 32'h0) begin
            bad++;
            $display("FAIL csum_clear: got=%h required=00000000", bus.Checksum);
        end
        send(3'd0, 5'd8,  5'd9, 5'd10, 6'h20, 16'h0,    26'h0);
        send(3'd1, 5'd29, 5'd8, 5'd0,  6'h0,  16'h0004, 26'h0);
        wait_done(dc);
        total++;
        if (bus.Checksum !== 32'h8EA15024) begin
            bad++;
            $display("FAIL csum_done: got=%h required=8EA15024", bus.Checksum);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_r();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_gaps_start();
        test_reset_mid();
`ifdef ENCODER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
